// File: rtl/branch_cache_update_ctrl.sv
// rtl/branch_cache_update_ctrl.sv - branch target cache write sequencer
// Queues jump resolutions, retires them on idle search cycles, and walks invalidates on flush.
module branch_cache_update_ctrl #(
  parameter int QDEPTH       = 4,
  parameter int INDEX_W      = 3,
  parameter int STARVE_LIMIT = 8
) (
  input  logic               iCLOCK,
  input  logic               iRESET_SYNC,
  input  logic               iFLUSH,
  input  logic               iSEARCH_STB,
  input  logic               iJUMP_STB,
  input  logic               iJUMP_VALID,
  input  logic [31:0]        iJUMP_ADDR,
  input  logic [31:0]        iJUMP_INST_ADDR,
  output logic               oJUMP_FULL,
  output logic               oBC_WR_STB,
  output logic               oBC_WR_VALID,
  output logic [31:0]        oBC_WR_ADDR,
  output logic [31:0]        oBC_WR_INST_ADDR,
  output logic               oBC_INV_STB,
  output logic [INDEX_W-1:0] oBC_INV_INDEX,
  output logic               oSEARCH_HOLD,
  output logic               oFLUSH_BUSY,
  output logic [7:0]         oDROP_CNT
);

  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [INDEX_W-1:0] LAST_IDX = {INDEX_W{1'b1}};

  typedef enum logic {RUN, WALK} state_t;

  state_t               r_state, w_state_nxt;
  logic [INDEX_W-1:0]   r_idx, w_idx_nxt;
  logic [64:0]          r_mem [QDEPTH];
  logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]        r_count, w_count_nxt;
  logic [7:0]           r_starve, w_starve_nxt;
  logic [7:0]           r_drop_cnt;
  logic                 r_full, r_wr_stb, r_wr_valid, r_inv_stb, r_hold, r_busy;
  logic [31:0]          r_wr_addr, r_wr_inst;
  logic [INDEX_W-1:0]   r_inv_index;
  logic                 w_full, w_run, w_push, w_pop, w_drop;
  logic [64:0]          w_head;

  assign w_full = (r_count == CW'(QDEPTH));
  assign w_run  = (r_state == RUN) && !iFLUSH;
  assign w_push = w_run && iJUMP_STB && !w_full;
  assign w_drop = w_run && iJUMP_STB && w_full;
  // A forced issue ignores the search; that search must be replayed by fetch.
  assign w_pop  = w_run && (r_count != '0) &&
                  (!iSEARCH_STB || (r_starve == 8'(STARVE_LIMIT)));
  assign w_head = r_mem[r_rd_ptr];

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      r_state <= RUN;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    if (iFLUSH) begin
      w_state_nxt = WALK;
      w_idx_nxt   = '0;
    end else if (r_state == WALK) begin
      if (r_idx == LAST_IDX) begin
        w_state_nxt = RUN;
        w_idx_nxt   = '0;
      end else begin
        w_idx_nxt = r_idx + 1'b1;
      end
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    if (iFLUSH) begin
      w_count_nxt = '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + CW'(1);
        2'b01:   w_count_nxt = r_count - CW'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  always_comb begin
    w_starve_nxt = r_starve;
    if (iFLUSH || w_pop || (r_count == '0)) begin
      w_starve_nxt = '0;
    end else if ((r_state == RUN) && iSEARCH_STB && (r_starve != 8'hFF)) begin
      w_starve_nxt = r_starve + 8'd1;
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (w_push) r_mem[r_wr_ptr] <= {iJUMP_VALID, iJUMP_ADDR, iJUMP_INST_ADDR};
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_starve    <= '0;
      r_drop_cnt  <= '0;
      r_full      <= 1'b0;
      r_wr_stb    <= 1'b0;
      r_wr_valid  <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_inst   <= '0;
      r_inv_stb   <= 1'b0;
      r_inv_index <= '0;
      r_hold      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      if (iFLUSH) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count  <= w_count_nxt;
      r_starve <= w_starve_nxt;
      if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
      r_wr_stb <= w_pop;
      r_hold   <= w_pop && iSEARCH_STB;
      if (w_pop) begin
        r_wr_valid <= w_head[64];
        r_wr_addr  <= w_head[63:32];
        r_wr_inst  <= w_head[31:0];
      end
      r_inv_stb   <= (w_state_nxt == WALK);
      r_busy      <= (w_state_nxt == WALK);
      r_inv_index <= (w_state_nxt == WALK) ? w_idx_nxt : '0;
      r_full      <= (w_count_nxt == CW'(QDEPTH)) || (w_state_nxt == WALK);
    end
  end

  assign oJUMP_FULL       = r_full;
  assign oBC_WR_STB       = r_wr_stb;
  assign oBC_WR_VALID     = r_wr_valid;
  assign oBC_WR_ADDR      = r_wr_addr;
  assign oBC_WR_INST_ADDR = r_wr_inst;
  assign oBC_INV_STB      = r_inv_stb;
  assign oBC_INV_INDEX    = r_inv_index;
  assign oSEARCH_HOLD     = r_hold;
  assign oFLUSH_BUSY      = r_busy;
  assign oDROP_CNT        = r_drop_cnt;

endmodule

// File: tb/tb_branch_cache_update_ctrl.sv
// tb/tb_branch_cache_update_ctrl.sv - directed bench with write scoreboard
// Expected cache writes are queued when jumps are driven and popped as oBC_WR_STB appears.
module tb_branch_cache_update_ctrl;

  logic        clk, rst, flush, search, jstb, jvalid;
  logic [31:0] jaddr, jinst;
  logic        full, wr_stb, wr_valid, inv_stb, hold, busy;
  logic [31:0] wr_addr, wr_inst;
  logic [2:0]  inv_index;
  logic [7:0]  drop_cnt;

  int n_pass = 0;
  int n_total = 0;
  bit mon_en = 0;
  logic [64:0] sb[$];
  logic [64:0] exp_w;

  branch_cache_update_ctrl #(.QDEPTH(4), .INDEX_W(3), .STARVE_LIMIT(8)) dut (
    .iCLOCK(clk), .iRESET_SYNC(rst), .iFLUSH(flush), .iSEARCH_STB(search),
    .iJUMP_STB(jstb), .iJUMP_VALID(jvalid), .iJUMP_ADDR(jaddr), .iJUMP_INST_ADDR(jinst),
    .oJUMP_FULL(full), .oBC_WR_STB(wr_stb), .oBC_WR_VALID(wr_valid), .oBC_WR_ADDR(wr_addr),
    .oBC_WR_INST_ADDR(wr_inst), .oBC_INV_STB(inv_stb), .oBC_INV_INDEX(inv_index),
    .oSEARCH_HOLD(hold), .oFLUSH_BUSY(busy), .oDROP_CNT(drop_cnt)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_jump(input logic v, input logic [31:0] a, input logic [31:0] ia,
                            input bit accepted);
    jstb = 1; jvalid = v; jaddr = a; jinst = ia;
    if (accepted) sb.push_back({v, a, ia});
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("wr_inv_exclusive", {64'd0, wr_stb & inv_stb}, 65'd0);
      if (wr_stb === 1'b1) begin
        n_total++;
        assert (sb.size() != 0) n_pass++;
        else $error("FAIL wr_unexpected observed=%0h expected=no_write", {wr_valid, wr_addr, wr_inst});
        if (sb.size() != 0) begin
          exp_w = sb.pop_front();
          chk("wr_fields", {wr_valid, wr_addr, wr_inst}, exp_w);
        end
      end
    end
  end

  initial begin
    rst = 1; flush = 0; search = 0; jstb = 0; jvalid = 0; jaddr = 0; jinst = 0;
    tick(); tick();
    chk("reset_outputs", {full, wr_stb, wr_valid, inv_stb, hold, busy, inv_index, drop_cnt},
        65'd0);
    rst = 0;
    mon_en = 1;

    // 1: single jump, idle search, 2-cycle issue
    drive_jump(1, 32'h100, 32'h40, 1);
    tick(); jstb = 0;
    chk("t1_wr_c1", {64'd0, wr_stb}, 65'd0);
    tick();
    chk("t1_wr_c2", {64'd0, wr_stb}, 65'd1);
    tick();
    chk("t1_wr_c3", {64'd0, wr_stb}, 65'd0);

    // 2: fill under search, fifth jump dropped, then drain in order
    search = 1;
    for (int i = 0; i < 5; i++) begin
      drive_jump(i[0], 32'h200 + 32'(i), 32'h80 + 32'(i), i < 4);
      tick();
    end
    jstb = 0;
    chk("t2_full", {64'd0, full}, 65'd1);
    chk("t2_drop", {57'd0, drop_cnt}, 65'd1);
    chk("t2_no_wr", {64'd0, wr_stb}, 65'd0);
    search = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_drain_stb", {64'd0, wr_stb}, 65'd1);
    end
    tick();
    chk("t2_drain_end", {64'd0, wr_stb}, 65'd0);
    chk("t2_not_full", {64'd0, full}, 65'd0);

    // 3: starvation guard forces the write after 8 blocked cycles
    search = 1;
    drive_jump(1, 32'h5A5A_0000, 32'h1234, 1);
    tick(); jstb = 0;
    for (int i = 0; i < 9; i++) begin
      chk("t3_blocked", {63'd0, wr_stb, hold}, 65'd0);
      tick();
    end
    chk("t3_forced", {63'd0, wr_stb, hold}, 65'd3);
    tick();
    chk("t3_after", {63'd0, wr_stb, hold}, 65'd0);

    // 4: flush with 3 queued entries
    for (int i = 0; i < 3; i++) begin
      drive_jump(0, 32'h900 + 32'(i), 32'h300 + 32'(i), 1);
      tick();
    end
    jstb = 0; search = 0; flush = 1;
    sb.delete();
    tick(); flush = 0;
    chk("t4_full_walk", {64'd0, full}, 65'd1);
    for (int i = 0; i < 8; i++) begin
      chk("t4_walk", {60'd0, busy, inv_stb, inv_index}, {60'd0, 2'b11, 3'(i)});
      tick();
    end
    chk("t4_done", {61'd0, busy, inv_stb, full, wr_stb}, 65'd0);
    tick(); tick();

    // 5: re-flush at index 5, jumps during walk ignored
    flush = 1;
    tick(); flush = 0;
    for (int i = 0; i < 5; i++) tick();
    chk("t5_idx5", {60'd0, busy, inv_stb, inv_index}, {60'd0, 2'b11, 3'd5});
    flush = 1;
    drive_jump(1, 32'hDEAD, 32'hBEEF, 0);
    tick(); flush = 0;
    for (int i = 0; i < 8; i++) begin
      chk("t5_walk", {60'd0, busy, inv_stb, inv_index}, {60'd0, 2'b11, 3'(i)});
      jstb = (i < 7);
      tick();
    end
    jstb = 0;
    chk("t5_done", {63'd0, busy, inv_stb}, 65'd0);
    chk("t5_drop", {57'd0, drop_cnt}, 65'd1);
    tick(); tick();

    // 6: reset mid-walk, then normal issue
    flush = 1;
    tick(); flush = 0;
    for (int i = 0; i < 3; i++) tick();
    chk("t6_idx3", {62'd0, inv_stb, inv_index[1:0]}, 65'd7);
    rst = 1;
    tick(); rst = 0;
    chk("t6_reset_outputs", {full, wr_stb, wr_valid, inv_stb, hold, busy, inv_index, drop_cnt},
        65'd0);
    drive_jump(0, 32'h300, 32'hC0, 1);
    tick(); jstb = 0;
    chk("t6_wr_c1", {64'd0, wr_stb}, 65'd0);
    tick();
    chk("t6_wr_c2", {64'd0, wr_stb}, 65'd1);
    tick(); tick();
    chk("sb_empty", 65'(sb.size()), 65'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
